// File: rtl/kpyd_scanner_if.sv
// Key-event output bundle of the keypad scanner.
// The master drives the event and overrun flag; the slave drives ready.
interface kpyd_scanner_if;
  logic [7:0] kpyd_o;
  logic       valid_o;
  logic       ready_i;
  logic       overrun_o;

  modport master (
    output kpyd_o,
    output valid_o,
    output overrun_o,
    input  ready_i
  );

  modport slave (
    input  kpyd_o,
    input  valid_o,
    input  overrun_o,
    output ready_i
  );
endinterface

// File: rtl/kpyd_scanner.sv
// 4x4 keypad scanner with press/release debounce and valid/ready output.
// Optional auto-repeat while held: define KPYD_SCANNER_REPEAT_EN.
module kpyd_scanner #(
  parameter int SCAN_CYCLES    = 1000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 64
) (
  input  logic           clk_i,
  input  logic           reset_i,
  input  logic [3:0]     col_i,
  output logic [3:0]     row_o,
  kpyd_scanner_if.master kp
);

  localparam int CW = $clog2(SCAN_CYCLES);
  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_dwell;
  logic [DW-1:0] r_cnt;
  logic [3:0]    r_row;
  logic [7:0]    r_cand;
  logic [7:0]    r_kpyd;
  logic          r_valid;
  logic          r_ovr;

  logic          w_sample;
  logic          w_onehot;
  logic          w_match;
  logic          w_last;
  logic          w_emit;
  logic          w_acc;
  logic [3:0]    w_rot;

  assign w_sample = (r_dwell == CW'(SCAN_CYCLES - 1));
  assign w_onehot = ($countones(col_i) == 1);
  assign w_match  = (col_i == r_cand[7:4]);
  assign w_last   = (r_cnt == DW'(DEBOUNCE_SCANS - 1));
  assign w_acc    = r_valid && kp.ready_i;
  assign w_rot    = {r_row[2:0], r_row[3]};

`ifdef KPYD_SCANNER_REPEAT_EN
  localparam int RW = $clog2(REPEAT_SCANS + 1);

  logic [RW-1:0] r_rep;
  logic          w_rep_last;

  assign w_rep_last = (r_rep == RW'(REPEAT_SCANS - 1));
  assign w_emit = w_sample && w_match &&
                  (((r_state == DEBOUNCE) && w_last) ||
                   ((r_state == HELD) && w_rep_last));

  // Count matching held samples; wrap on each repeat event
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_rep <= '0;
    end else if (w_sample) begin
      if (r_state != HELD || !w_match) r_rep <= '0;
      else if (w_rep_last)             r_rep <= '0;
      else                             r_rep <= r_rep + 1'b1;
    end
  end
`else
  logic w_unused_rep;

  assign w_unused_rep = |32'(REPEAT_SCANS);
  assign w_emit = w_sample && w_match &&
                  (r_state == DEBOUNCE) && w_last;
`endif

  // Free-running dwell counter defines the sample point
  always_ff @(posedge clk_i) begin
    if (reset_i)       r_dwell <= '0;
    else if (w_sample) r_dwell <= '0;
    else               r_dwell <= r_dwell + 1'b1;
  end

  // Scan / debounce / held sequencing, acting only at sample points
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= SCAN;
      r_row   <= 4'b0001;
      r_cand  <= '0;
      r_cnt   <= '0;
    end else if (w_sample) begin
      unique case (r_state)
        SCAN: begin
          if (w_onehot) begin
            r_cand  <= {col_i, r_row};
            r_cnt   <= '0;
            r_state <= DEBOUNCE;
          end else begin
            r_row <= w_rot;
          end
        end
        DEBOUNCE: begin
          if (!w_match) begin
            r_state <= SCAN;
            r_row   <= w_rot;
          end else if (w_last) begin
            r_cnt   <= '0;
            r_state <= HELD;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        HELD: begin
          if (col_i != 4'b0000) begin
            r_cnt <= '0;
          end else if (w_last) begin
            r_cnt   <= '0;
            r_state <= SCAN;
            r_row   <= w_rot;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= SCAN;
        end
      endcase
    end
  end

  // Output slot: load on emit when free or being drained, else flag overrun
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_kpyd  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else if (w_emit) begin
      if (!r_valid || w_acc) begin
        r_kpyd  <= r_cand;
        r_valid <= 1'b1;
      end else begin
        r_ovr <= 1'b1;
      end
    end else if (w_acc) begin
      r_valid <= 1'b0;
    end
  end

  assign row_o        = r_row;
  assign kp.kpyd_o    = r_kpyd;
  assign kp.valid_o   = r_valid;
  assign kp.overrun_o = r_ovr;

endmodule

// File: tb/tb_kpyd_scanner.sv
// Scoreboard bench for kpyd_scanner against a procedural keypad model.
// Build with or without KPYD_SCANNER_REPEAT_EN to match the RTL.
`timescale 1ns/1ps
module tb_kpyd_scanner;

  localparam int SC = 4;
  localparam int DS = 2;
  localparam int RS = 3;

  logic       clk_i   = 1'b0;
  logic       reset_i = 1'b1;
  logic [3:0] col_i;
  logic [3:0] row_o;
  logic [3:0] keys [4];

  kpyd_scanner_if kp ();

  kpyd_scanner #(
    .SCAN_CYCLES   (SC),
    .DEBOUNCE_SCANS(DS),
    .REPEAT_SCANS  (RS)
  ) dut (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .col_i  (col_i),
    .row_o  (row_o),
    .kp     (kp)
  );

  always #5 clk_i = ~clk_i;

  always_comb begin
    col_i = 4'b0000;
    for (int r = 0; r < 4; r++)
      if (row_o[r]) col_i = col_i | keys[r];
  end

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always @(posedge clk_i)
    if (reset_i) cyc <= 0;
    else         cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  int         m_row   = 0;
  bit         m_valid = 0;
  bit         m_ovr   = 0;
  bit         m_vpre  = 0;
  bit         m_acc   = 0;
  int         m_phase = 0;
  logic [7:0] exp_q [$];

  task automatic wait_sample(output bit ab);
    ab = 0;
    forever begin
      @(posedge clk_i);
      if (reset_i) begin
        ab = 1; m_phase = 0; m_row = 0;
        m_valid = 0; m_ovr = 0; exp_q.delete();
        return;
      end
      m_vpre = m_valid;
      m_acc  = m_valid && kp.ready_i;
      if (m_acc) m_valid = 0;
      if (m_phase == SC - 1) begin
        m_phase = 0;
        return;
      end
      m_phase++;
    end
  endtask

  task automatic emit(logic [7:0] code);
    if (!m_vpre || m_acc) begin
      m_valid = 1;
      exp_q.push_back(code);
    end else begin
      m_ovr = 1;
    end
  endtask

  initial begin : model
    bit         ab;
    logic [3:0] c;
    logic [7:0] cand;
    int         n;
    int         rep;
    forever begin
      forever begin
        wait_sample(ab);
        if (ab) break;
        c = keys[m_row];
        if ($countones(c) == 1) break;
        m_row = (m_row + 1) % 4;
      end
      if (ab) continue;
      cand = {c, 4'(1 << m_row)};
      n = 0;
      while (n < DS) begin
        wait_sample(ab);
        if (ab) break;
        if (keys[m_row] == cand[7:4]) n++;
        else break;
      end
      if (ab) continue;
      if (n < DS) begin
        m_row = (m_row + 1) % 4;
        continue;
      end
      emit(cand);
      n = 0;
      rep = 0;
      while (n < DS) begin
        wait_sample(ab);
        if (ab) break;
        if (keys[m_row] == 4'b0000) n++;
        else n = 0;
`ifdef KPYD_SCANNER_REPEAT_EN
        if (keys[m_row] == cand[7:4]) begin
          rep++;
          if (rep == RS) begin
            rep = 0;
            emit(cand);
          end
        end else begin
          rep = 0;
        end
`endif
      end
      if (ab) continue;
      m_row = (m_row + 1) % 4;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk_i) begin
    chk("row_o", 32'(row_o), 32'(1 << m_row));
    chk("valid_o", 32'(kp.valid_o), 32'(m_valid));
    chk("overrun_o", 32'(kp.overrun_o), 32'(m_ovr));
    if (kp.valid_o) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", 32'(kp.kpyd_o), 32'hFFFF_FFFF);
      end else begin
        chk("kpyd_o", 32'(kp.kpyd_o), 32'(exp_q[0]));
        if (kp.ready_i) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic clr_keys();
    for (int r = 0; r < 4; r++) keys[r] = 4'b0000;
  endtask

  task automatic do_reset();
    clr_keys();
    reset_i = 1'b1;
    step();
    chk("rst_row", 32'(row_o), 32'h1);
    chk("rst_kpyd", 32'(kp.kpyd_o), 32'h0);
    chk("rst_valid", 32'(kp.valid_o), 32'h0);
    chk("rst_ovr", 32'(kp.overrun_o), 32'h0);
    step();
    reset_i = 1'b0;
  endtask

  task automatic wait_valid(string name, int max);
    int k = 0;
    while (!kp.valid_o && k < max) begin
      step();
      k++;
    end
    if (!kp.valid_o) chk(name, 32'(kp.valid_o), 32'h1);
  endtask

  initial begin
    int cnt;
    int hold;
    int r;
    kp.ready_i = 1'b1;
    clr_keys();

    // 1: basic press on row2/col1
    do_reset();
    kp.ready_i = 1'b1;
    keys[2] = 4'b0010;
    wait_valid("t1_timeout", 60);
    chk("t1_cycle", 32'(cyc), 32'd20);
    chk("t1_code", 32'(kp.kpyd_o), 32'h24);
    step();
    chk("t1_clear", 32'(kp.valid_o), 32'h0);
    chk("t1_row_held", 32'(row_o), 32'h4);
    keys[2] = 4'b0000;
    repeat (20) step();

    // 2: bounce during debounce
    do_reset();
    keys[2] = 4'b0010;
    while (cyc < 15) step();
    keys[2] = 4'b0000;
    step();
    keys[2] = 4'b0010;
    chk("t2_rot", 32'(row_o), 32'h8);
    wait_valid("t2_timeout", 80);
    chk("t2_code", 32'(kp.kpyd_o), 32'h24);
    keys[2] = 4'b0000;
    repeat (20) step();

    // 3: ghosting pattern is ignored
    do_reset();
    keys[0] = 4'b0011;
    while (cyc < 4) step();
    chk("t3_rot", 32'(row_o), 32'h2);
    repeat (40) step();
    keys[0] = 4'b0000;
    repeat (10) step();

    // 4: overrun with ready low
    do_reset();
    kp.ready_i = 1'b0;
    keys[0] = 4'b0001;
    wait_valid("t4_timeout", 60);
    chk("t4_code1", 32'(kp.kpyd_o), 32'h11);
    keys[0] = 4'b0000;
    repeat (30) step();
    keys[3] = 4'b1000;
    cnt = 0;
    while (!kp.overrun_o && cnt < 100) begin
      step();
      cnt++;
    end
    chk("t4_ovr", 32'(kp.overrun_o), 32'h1);
    chk("t4_keep", 32'(kp.kpyd_o), 32'h11);
    chk("t4_valid", 32'(kp.valid_o), 32'h1);
    keys[3] = 4'b0000;
    kp.ready_i = 1'b1;
    step();
    chk("t4_drain", 32'(kp.valid_o), 32'h0);
    chk("t4_sticky", 32'(kp.overrun_o), 32'h1);
    repeat (20) step();

    // 5: reset while holding an event
    do_reset();
    kp.ready_i = 1'b0;
    keys[1] = 4'b0001;
    wait_valid("t5_timeout", 60);
    repeat (2) step();
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    chk("t5_row", 32'(row_o), 32'h1);
    chk("t5_valid", 32'(kp.valid_o), 32'h0);
    chk("t5_kpyd", 32'(kp.kpyd_o), 32'h0);
    chk("t5_ovr", 32'(kp.overrun_o), 32'h0);
    keys[1] = 4'b0000;
    kp.ready_i = 1'b1;

    // 6: long hold, event count
    do_reset();
    kp.ready_i = 1'b1;
    keys[1] = 4'b0100;
    cnt = 0;
    for (int i = 1; i <= 85; i++) begin
      step();
      if (kp.valid_o) cnt++;
    end
`ifdef KPYD_SCANNER_REPEAT_EN
    chk("t6_events", 32'(cnt), 32'd6);
`else
    chk("t6_events", 32'(cnt), 32'd1);
`endif
    keys[1] = 4'b0000;
    repeat (20) step();

    // random key activity with random backpressure
    do_reset();
    for (int it = 0; it < 40; it++) begin
      clr_keys();
      r = $urandom_range(0, 9);
      if (r < 6) begin
        keys[$urandom_range(0, 3)] = 4'(1 << $urandom_range(0, 3));
      end else if (r >= 8) begin
        keys[$urandom_range(0, 3)] = 4'(1 << $urandom_range(0, 3));
        keys[$urandom_range(0, 3)] |= 4'(1 << $urandom_range(0, 3));
      end
      hold = $urandom_range(4, 60);
      for (int k = 0; k < hold; k++) begin
        kp.ready_i = ($urandom_range(0, 3) != 0);
        step();
      end
    end
    clr_keys();
    kp.ready_i = 1'b1;
    repeat (40) step();
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
